// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: a direct-mapped line store that serves hits directly.
// Misses are refilled by a 4-beat 64-bit burst, and flush squashes the response to a fetch still in flight.
module instr_mem_responder #(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        mem_read,
    input  logic [31:0] mem_address,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic [31:0] pmem_address,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int TAG_W = 32 - 5 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RESP
    } state_e;

    state_e             state_q;
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [NUM_SETS];
    logic [31:0]        data_q [NUM_SETS][8];
    logic [1:0]         cnt_q;
    logic               kill_q;
    logic [29:0]        addr_q;
    logic [31:0]        mem_rdata_q;
    logic               mem_resp_q;
    logic               pmem_read_q;
    logic [31:0]        pmem_addr_q;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [2:0]         req_word;
    logic               req_hit;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic [2:0]         fill_word;
    logic               last_beat;
    logic [31:0]        fill_word_d;
    logic               unused_addr_bits;

    assign req_idx   = mem_address[5 +: IDX_W];
    assign req_tag   = mem_address[31 -: TAG_W];
    assign req_word  = mem_address[4:2];
    assign req_hit   = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    assign fill_idx  = addr_q[3 +: IDX_W];
    assign fill_tag  = addr_q[29 -: TAG_W];
    assign fill_word = addr_q[2:0];
    assign last_beat = (state_q == S_FILL) && pmem_resp && (cnt_q == 2'd3);

    assign unused_addr_bits = ^mem_address[1:0];

    // Words 6/7 arrive on the final beat and are not yet in the store, so forward them.
    always_comb begin
        fill_word_d = data_q[fill_idx][fill_word];
        if (fill_word[2:1] == 2'd3) begin
            fill_word_d = fill_word[0] ? pmem_rdata[63:32] : pmem_rdata[31:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            cnt_q       <= '0;
            kill_q      <= 1'b0;
            addr_q      <= '0;
            mem_rdata_q <= '0;
            mem_resp_q  <= 1'b0;
            pmem_read_q <= 1'b0;
            pmem_addr_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_read && !flush) begin
                        if (req_hit) begin
                            mem_rdata_q <= data_q[req_idx][req_word];
                            mem_resp_q  <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            addr_q           <= mem_address[31:2];
                            valid_q[req_idx] <= 1'b0;
                            pmem_read_q      <= 1'b1;
                            pmem_addr_q      <= {mem_address[31:5], 5'b0};
                            state_q          <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (pmem_resp) begin
                        if (cnt_q == 2'd3) begin
                            cnt_q             <= '0;
                            valid_q[fill_idx] <= 1'b1;
                            pmem_read_q       <= 1'b0;
                            kill_q            <= 1'b0;
                            if (kill_q || flush) begin
                                state_q <= S_IDLE;
                            end else begin
                                mem_rdata_q <= fill_word_d;
                                mem_resp_q  <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                S_RESP: begin
                    mem_resp_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if ((state_q == S_FILL) && pmem_resp) begin
            data_q[fill_idx][{cnt_q, 1'b0}] <= pmem_rdata[31:0];
            data_q[fill_idx][{cnt_q, 1'b1}] <= pmem_rdata[63:32];
            if (last_beat) begin
                tag_q[fill_idx] <= fill_tag;
            end
        end
    end

    assign mem_rdata    = mem_rdata_q;
    assign mem_resp     = mem_resp_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_address = pmem_addr_q;

endmodule
